// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arbiter_pkg;
    localparam int DATA_W = 32;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, memory and status signals of the arbiter; slave = arbiter side, master = requesters + memory.
interface dmem_arbiter_if;
    import dmem_arbiter_pkg::*;

    logic              p0_req, p0_we, p0_gnt, p0_rvalid, p0_err;
    logic [DATA_W-1:0] p0_addr, p0_wdata, p0_rdata;
    logic              p1_req, p1_we, p1_gnt, p1_rvalid, p1_err;
    logic [DATA_W-1:0] p1_addr, p1_wdata, p1_rdata;
    logic              mem_read, mem_write, busy;
    logic [DATA_W-1:0] mem_addr, mem_wdata, mem_rdata;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err,
        output mem_read, mem_write, mem_addr, mem_wdata, busy
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
        input  mem_read, mem_write, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: on contention the port not granted last wins.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_gnt
);
    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11)
            o_gnt = i_last_grant ? 2'b01 : 2'b10;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between two requesters, one access at a time,
// with a mandatory control-deassert cycle between accesses.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MEM_LAT   = 1,
    parameter int ADDR_BITS = 8
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_owner, r_we, r_oor, r_last;
    logic [DATA_W-1:0] r_cap, r_rdata;
    logic [1:0]        r_gnt, r_rvalid;
    logic              r_err;
    logic              r_mem_read, r_mem_write;
    logic [DATA_W-1:0] r_mem_addr, r_mem_wdata;

    logic [1:0]        w_req, w_win;
    logic              w_win_id, w_sel_we, w_oor;
    logic [DATA_W-1:0] w_sel_addr, w_sel_wdata;

    assign w_req = {bus.p1_req, bus.p0_req};

    rr_arb2 u_arb (
        .i_req        (w_req),
        .i_last_grant (r_last),
        .o_gnt        (w_win)
    );

    assign w_win_id    = w_win[1];
    assign w_sel_we    = w_win_id ? bus.p1_we    : bus.p0_we;
    assign w_sel_addr  = w_win_id ? bus.p1_addr  : bus.p0_addr;
    assign w_sel_wdata = w_win_id ? bus.p1_wdata : bus.p0_wdata;
    // Shift rather than slice so ADDR_BITS == DATA_W stays legal.
    assign w_oor       = |(w_sel_addr >> ADDR_BITS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_owner     <= P0;
            r_we        <= 1'b0;
            r_oor       <= 1'b0;
            r_last      <= P1;
            r_cap       <= '0;
            r_rdata     <= '0;
            r_gnt       <= '0;
            r_rvalid    <= '0;
            r_err       <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_gnt    <= '0;
            r_rvalid <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_owner <= w_win_id;
                        r_we    <= w_sel_we;
                        r_oor   <= w_oor;
                        r_gnt   <= w_win;
                        r_last  <= w_win_id;
                        r_cnt   <= '0;
                        if (w_oor) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state     <= ST_ACCESS;
                            r_mem_read  <= ~w_sel_we;
                            r_mem_write <= w_sel_we;
                            r_mem_addr  <= w_sel_addr;
                            r_mem_wdata <= w_sel_wdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(MEM_LAT - 1)) begin
                        r_cap       <= r_we ? '0 : bus.mem_rdata;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_rvalid[r_owner] <= 1'b1;
                    r_err             <= r_oor;
                    r_rdata           <= (r_we || r_oor) ? '0 : r_cap;
                    r_state           <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.p0_gnt    = r_gnt[0];
    assign bus.p1_gnt    = r_gnt[1];
    assign bus.p0_rvalid = r_rvalid[0];
    assign bus.p1_rvalid = r_rvalid[1];
    assign bus.p0_err    = r_rvalid[0] & r_err;
    assign bus.p1_err    = r_rvalid[1] & r_err;
    assign bus.p0_rdata  = r_rvalid[0] ? r_rdata : '0;
    assign bus.p1_rdata  = r_rvalid[1] ? r_rdata : '0;
    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = (r_state != ST_IDLE);
endmodule
